// File: rtl/otter_mem_scrubber.sv
// Background ECC scrubber and memory-port arbiter for Hamming(38,32) protected data memory.
// Optional build macro OTTER_SCRUB_STATS_EN adds saturating CORR_CNT / UNCORR_CNT outputs.
module otter_mem_scrubber #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned SCRUB_INTERVAL = 1024,
  parameter int unsigned RD_LAT         = 1
) (
  input  logic              MEM_CLK,
  input  logic              RST_N,
  input  logic              SCRUB_EN,
  input  logic              CPU_REQ,
  output logic              CPU_STALL,
  output logic              SCRUB_GNT,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RDEN,
  output logic              MEM_WE,
  output logic [31:0]       MEM_WDATA,
  output logic [5:0]        MEM_WPAR,
  input  logic [31:0]       MEM_RDATA,
  input  logic [5:0]        MEM_RPAR,
  output logic              ERR_CORR,
  output logic              ERR_UNCORR,
`ifdef OTTER_SCRUB_STATS_EN
  output logic [15:0]       CORR_CNT,
  output logic [15:0]       UNCORR_CNT,
`endif
  output logic [ADDR_W-1:0] ERR_ADDR,
  output logic              PASS_DONE
);

  localparam int unsigned CntW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCRUB_INTERVAL - 1);
  localparam logic [LatW-1:0] LatMax = LatW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRead,
    StLat,
    StCheck,
    StWrite,
    StNext
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [LatW-1:0] lat_q;
  logic [31:0]     rdata_q;
  logic [5:0]      rpar_q;

  logic [5:0]  syn;
  logic        syn_pow2;
  logic        syn_data;
  logic [31:0] fix_data;
  logic [5:0]  fix_par;

  // Parity k covers every data position (1-based, 1..38) whose index has bit k set.
  function automatic logic [5:0] ecc_par(input logic [31:0] d);
    logic [5:0] p;
    logic [5:0] pos;
    logic [4:0] di;
    p  = '0;
    di = '0;
    for (int i = 1; i <= 38; i++) begin
      pos = 6'(i);
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        for (int k = 0; k < 6; k++) begin
          if (pos[k]) p[k] = p[k] ^ d[di];
        end
        di = di + 5'd1;
      end
    end
    return p;
  endfunction

  // Flips the data bit living at code position s; no-op for 0, powers of 2 and s > 38.
  function automatic logic [31:0] ecc_fix(input logic [31:0] d, input logic [5:0] s);
    logic [31:0] r;
    logic [5:0]  pos;
    logic [4:0]  di;
    r  = d;
    di = '0;
    for (int i = 1; i <= 38; i++) begin
      pos = 6'(i);
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        if (pos == s) r[di] = ~r[di];
        di = di + 5'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    syn      = ecc_par(rdata_q) ^ rpar_q;
    syn_pow2 = (syn != 6'd0) && ((syn & (syn - 6'd1)) == 6'd0);
    syn_data = (syn != 6'd0) && !syn_pow2 && (syn <= 6'd38);
    fix_data = ecc_fix(rdata_q, syn);
    fix_par  = ecc_par(fix_data);
  end

  assign CPU_STALL = CPU_REQ & SCRUB_GNT;

  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lat_q      <= '0;
      rdata_q    <= '0;
      rpar_q     <= '0;
      SCRUB_GNT  <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_RDEN   <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_WDATA  <= '0;
      MEM_WPAR   <= '0;
      ERR_CORR   <= 1'b0;
      ERR_UNCORR <= 1'b0;
      ERR_ADDR   <= '0;
      PASS_DONE  <= 1'b0;
`ifdef OTTER_SCRUB_STATS_EN
      CORR_CNT   <= '0;
      UNCORR_CNT <= '0;
`endif
    end else begin
      MEM_RDEN   <= 1'b0;
      MEM_WE     <= 1'b0;
      ERR_CORR   <= 1'b0;
      ERR_UNCORR <= 1'b0;
      PASS_DONE  <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (SCRUB_EN) state_q <= StWait;
        end
        StWait: begin
          if (!SCRUB_EN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            // A pending CPU request parks the counter at its terminal value.
            if (!CPU_REQ) begin
              state_q   <= StRead;
              cnt_q     <= '0;
              MEM_RDEN  <= 1'b1;
              SCRUB_GNT <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRead: begin
          state_q <= StLat;
          lat_q   <= '0;
        end
        StLat: begin
          if (lat_q == LatMax) begin
            rdata_q <= MEM_RDATA;
            rpar_q  <= MEM_RPAR;
            state_q <= StCheck;
          end else begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        StCheck: begin
          if (syn_pow2 || syn_data) begin
            MEM_WDATA <= fix_data;
            MEM_WPAR  <= fix_par;
            MEM_WE    <= 1'b1;
            ERR_CORR  <= 1'b1;
            ERR_ADDR  <= MEM_ADDR;
            state_q   <= StWrite;
`ifdef OTTER_SCRUB_STATS_EN
            if (CORR_CNT != 16'hFFFF) CORR_CNT <= CORR_CNT + 16'd1;
`endif
          end else begin
            if (syn != 6'd0) begin
              ERR_UNCORR <= 1'b1;
              ERR_ADDR   <= MEM_ADDR;
`ifdef OTTER_SCRUB_STATS_EN
              if (UNCORR_CNT != 16'hFFFF) UNCORR_CNT <= UNCORR_CNT + 16'd1;
`endif
            end
            SCRUB_GNT <= 1'b0;
            state_q   <= StNext;
          end
        end
        StWrite: begin
          SCRUB_GNT <= 1'b0;
          state_q   <= StNext;
        end
        StNext: begin
          MEM_ADDR  <= MEM_ADDR + ADDR_W'(1);
          PASS_DONE <= (MEM_ADDR == {ADDR_W{1'b1}});
          state_q   <= SCRUB_EN ? StWait : StIdle;
        end
        default: begin
          SCRUB_GNT <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule
